// File: rtl/irq_pkg.sv
// Shared constants for the external interrupt controller: register map,
// FSM state encoding and STATUS field positions.
package irq_pkg;

    localparam logic [1:0] IRQ_MASK = 2'd0;
    localparam logic [1:0] IRQ_EDGE = 2'd1;
    localparam logic [1:0] IRQ_PEND = 2'd2;
    localparam logic [1:0] IRQ_STAT = 2'd3;

    localparam int STAT_BUSY_BIT = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_sync.sv
// Per-line two-flop synchroniser with a third flop that delays the
// synchronised level so a clean single-cycle rise pulse can be derived.
module irq_sync #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_level,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;
    logic [W-1:0] r_s3;

    // Synchroniser chain plus edge-detect delay stage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s3;

endmodule

// File: rtl/irq_ctrl.sv
// External interrupt controller feeding CP0's rising-edge ir_in: latches and
// masks N lines, arbitrates lowest-index-first, holds the request until ERET.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int ID_W  = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    input  logic             eret,
    output logic             ir_out,
    output logic [ID_W-1:0]  cur_id
);

    irq_state_e       r_state;
    irq_state_e       w_state_nxt;
    logic [N_IRQ-1:0] r_mask;
    logic [N_IRQ-1:0] r_edge;
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] w_pend_nxt;
    logic [N_IRQ-1:0] w_level;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_wdata;
    logic [N_IRQ-1:0] w_w1c;
    logic [N_IRQ-1:0] w_cap;
    logic [N_IRQ-1:0] w_cand;
    logic [N_IRQ-1:0] w_win_oh;
    logic [ID_W-1:0]  w_winner;
    logic             w_any;
    logic             w_load_id;
    logic             w_ir_nxt;
    logic             w_busy;
    logic             r_ir_out;
    logic [ID_W-1:0]  r_cur_id;
    logic [31:0]      w_stat;

    irq_sync #(.W(N_IRQ)) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_async (irq_in),
        .o_level (w_level),
        .o_rise  (w_rise)
    );

    assign w_wdata = cfg_wdata[N_IRQ-1:0];

    // Software-visible MASK and EDGE configuration registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mask <= '0;
            r_edge <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                IRQ_MASK: r_mask <= w_wdata;
                IRQ_EDGE: r_edge <= w_wdata;
                default:  ;
            endcase
        end
    end

    // Priority encoder: isolate the lowest set candidate bit, then encode it
    always_comb begin
        w_cand   = r_pend & r_mask;
        w_win_oh = w_cand & (~w_cand + {{(N_IRQ-1){1'b0}}, 1'b1});
        w_any    = |w_cand;
        w_winner = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_winner = w_winner | ({ID_W{w_win_oh[i]}} & ID_W'(i));
        end
    end

    // Pending next-state: a fresh rise on an edge line outranks any clear
    always_comb begin
        w_pend_nxt = r_pend;
        if (cfg_we && (cfg_addr == IRQ_PEND)) begin
            w_w1c = w_wdata;
        end else begin
            w_w1c = '0;
        end
        if (w_load_id) begin
            w_cap = w_win_oh;
        end else begin
            w_cap = '0;
        end
        for (int i = 0; i < N_IRQ; i++) begin
            if (r_edge[i]) begin
                w_pend_nxt[i] = w_rise[i] | (r_pend[i] & ~(w_w1c[i] | w_cap[i]));
            end else begin
                w_pend_nxt[i] = w_level[i];
            end
        end
    end

    // Pending register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; GAP always lasts exactly one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (eret) begin
                    w_state_nxt = ST_GAP;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM output decode, fed into the output registers below
    always_comb begin
        w_busy    = (r_state != ST_IDLE);
        w_ir_nxt  = (w_state_nxt == ST_REQ);
        if (r_state == ST_IDLE) begin
            w_load_id = w_any;
        end else begin
            w_load_id = 1'b0;
        end
    end

    // Registered request line and in-service identifier
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ir_out <= 1'b0;
            r_cur_id <= '0;
        end else begin
            r_ir_out <= w_ir_nxt;
            if (w_load_id) begin
                r_cur_id <= w_winner;
            end
        end
    end

    assign ir_out = r_ir_out;
    assign cur_id = r_cur_id;

    // Register read mux; unused upper bits read as zero
    always_comb begin
        w_stat                = '0;
        w_stat[STAT_BUSY_BIT] = w_busy;
        w_stat[ID_W-1:0]      = r_cur_id;
        case (cfg_addr)
            IRQ_MASK: cfg_rdata = 32'(r_mask);
            IRQ_EDGE: cfg_rdata = 32'(r_edge);
            IRQ_PEND: cfg_rdata = 32'(r_pend);
            IRQ_STAT: cfg_rdata = w_stat;
            default:  cfg_rdata = 32'd0;
        endcase
    end

endmodule
